key_conditioner: RTL and testbench
==================================

# key_conditioner

Input conditioning stage between the raw key sources (PS/2 decoder levels ORed with board buttons) and the game logic. It synchronises and debounces five key levels and turns presses into single-cycle move pulses aligned to the 60 Hz game tick. Horizontal and soft-drop keys get delayed auto-repeat; rotate and hard drop are single-shot. Its outputs replace the raw level ORs that currently feed the game.

## Interface
- `DEBOUNCE_CYCLES`, default 834600: consecutive stable `clk` cycles required to accept a level change (about 10 ms at 83.46 MHz). Must be at least 1.
- `DAS_TICKS`, default 16: game ticks from the first pulse to the first repeat pulse.
- `ARR_TICKS`, default 6: game ticks between subsequent repeat pulses.
- `clk` in 1: pixel clock. The only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `tick_game` in 1: one-cycle strobe at 60 Hz.
- `key_raw` in 5: asynchronous levels, bit order [0] left, [1] right, [2] down, [3] rotate, [4] drop.
- `key_pulse` out 5: one-cycle move requests, same bit order.
- `key_held` out 5: debounced levels, same bit order.

## Operation
- **Per-channel sync and debounce**
  - Each channel passes through a 2-FF synchroniser.
  - A per-channel counter compares the synchronised input against the accepted level.
  - On a mismatch the counter increments. When the counter reaches `DEBOUNCE_CYCLES - 1` on a mismatching cycle, the accepted level flips and the counter clears.
  - Any matching cycle clears the counter.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- **Per-channel FSM**
  - States: IDLE, DELAY, REPEAT. The tick counter width is `$clog2(max(DAS_TICKS, ARR_TICKS)+1)`.
  - IDLE: an accepted rising edge sets `pending` and moves to DELAY with the counter at 0.
  - DELAY: each `tick_game` increments the counter. When it reaches `DAS_TICKS`, set `pending`, go to REPEAT, and clear the counter.
  - REPEAT: each tick increments the counter. When it reaches `ARR_TICKS`, set `pending` and clear the counter.
  - An accepted falling edge in any state returns to IDLE and clears the counter and `pending`.
  - Rotate and drop never leave DELAY via the DAS path; they stay in DELAY until release.
- **Emission**
  - `key_pulse[i] = pending[i] & tick_game & ~mask[i]`, registered.
  - `pending[i]` clears on any tick, whether the pulse was emitted or masked.
  - A press edge coinciding with `tick_game` is emitted on that same tick.
  - A DELAY or REPEAT terminal count reached on a tick sets `pending` for the next tick. This is exactly `DAS_TICKS + 1` ticks between the first two pulses.
- **Left+right conflict**: while `key_held[0]` and `key_held[1]` are both 1, both left and right pulses are masked. Their FSMs keep counting.
- **Reset**: all outputs 0, all accepted levels 0, all FSMs IDLE, counters and `pending` 0. Asserting reset mid-hold behaves as a full release; the still-held key needs a fresh debounce before it produces a pulse.

## Timing
- Press-to-accept latency: 2 sync cycles plus `DEBOUNCE_CYCLES` cycles. `key_held` changes 1 cycle after acceptance.
- Press-to-pulse: `key_pulse` is high for exactly the one `clk` cycle after the next `tick_game` cycle, which is a 1-cycle registered delay. The game samples pulses on the following cycle.
- No more than one pulse per channel per tick.
- A glitch shorter than `DEBOUNCE_CYCLES` produces no `key_held` change and no pulse.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: left, right and down auto-repeat as described above.
- `KEY_AUTOREPEAT_EN` undefined: every channel is single-shot, exactly one pulse per accepted press. The REPEAT state and tick counters are not synthesised.

## Structure
- `key_pkg` holds:
  - key index constants `KEY_LEFT`=0 through `KEY_DROP`=4 and `NUM_KEYS`=5;
  - `typedef enum logic [1:0] {KS_IDLE, KS_DELAY, KS_REPEAT} key_state_t`;
  - the repeat-capable mask `5'b00111`.
- Sub-module `key_debounce`: one channel's synchroniser and debounce counter, outputs the accepted level. It is instantiated 5 times. The FSMs, masking and emission live in `key_conditioner`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `DAS_TICKS`=3, `ARR_TICKS`=2, `tick_game` every 10 cycles.
- Bounce rejection: toggle left with 3-cycle pulses for 40 cycles, then release. Required: `key_held[0]` stays 0 and no pulse.
- Single press: hold rotate for 100 cycles, then release. Required: exactly one `key_pulse[3]` one cycle after the first tick following acceptance; `key_held[3]` is 1 for about 100 cycles.
- Auto-repeat: hold left for 200 cycles. Required: pulses on ticks T0, T0+4, T0+7, T0+10, and so on (spacing 4, then 3). Without `KEY_AUTOREPEAT_EN`: only T0.
- Left+right conflict: hold left, then add right 50 cycles later. Required: no bit-0 or bit-1 pulses while both are held. Releasing left lets right's pending or repeat pulses resume on the next tick.
- Press on tick: align acceptance with `tick_game`. Required: a pulse on the very next cycle.
- Reset mid-hold: hold drop, pulse `rst_n` low for 1 cycle. Required: all outputs 0 the cycle after. `key_held[4]` returns 1 after 2+4 cycles and a new pulse follows on the next tick.

Source files
------------

// File: rtl/key_pkg.sv
// Shared key indices, per-key state encoding and the set of keys that may auto-repeat.
package key_pkg;

    localparam int KEY_LEFT   = 0;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_DOWN   = 2;
    localparam int KEY_ROTATE = 3;
    localparam int KEY_DROP   = 4;
    localparam int NUM_KEYS   = 5;

    typedef enum logic [1:0] {KS_IDLE, KS_DELAY, KS_REPEAT} key_state_t;

    localparam logic [NUM_KEYS-1:0] REPEAT_MASK = 5'b00111;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-FF synchroniser followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive mismatching cycles.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 834600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_i,
    output logic level_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounced key levels turned into single-cycle move pulses aligned to the game tick.
// Define KEY_AUTOREPEAT_EN to give left/right/down delayed auto-repeat; otherwise all keys are single-shot.
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 834600,
    parameter int DAS_TICKS       = 16,
    parameter int ARR_TICKS       = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_game,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_held
);

    logic [NUM_KEYS-1:0] acc_lvl, rise, fall, mask;
    logic [NUM_KEYS-1:0] held_q, pending_q, pending_d, pulse_q, pulse_d;
    logic                conflict;
    key_state_t          state_q [NUM_KEYS];
    key_state_t          state_d [NUM_KEYS];

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .key_raw_i(key_raw[g]),
            .level_o  (acc_lvl[g])
        );
    end

    // held_q lags the accepted level by one cycle, so the difference is the accepted edge.
    assign rise     = acc_lvl & ~held_q;
    assign fall     = ~acc_lvl & held_q;
    assign conflict = held_q[KEY_LEFT] & held_q[KEY_RIGHT];

    always_comb begin
        mask            = '0;
        mask[KEY_LEFT]  = conflict;
        mask[KEY_RIGHT] = conflict;
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int                TICK_MAX = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
    localparam int                TICK_W   = $clog2(TICK_MAX + 1);
    localparam logic [TICK_W-1:0] DAS_LAST = TICK_W'(DAS_TICKS);
    localparam logic [TICK_W-1:0] ARR_LAST = TICK_W'(ARR_TICKS);

    logic [TICK_W-1:0] tcnt_q [NUM_KEYS];
    logic [TICK_W-1:0] tcnt_d [NUM_KEYS];
    logic [TICK_W-1:0] tick_nxt;
`else
    logic unused_cfg;
    // Repeat timing has no meaning when every key is single-shot.
    assign unused_cfg = (DAS_TICKS + ARR_TICKS) > 0;
`endif

    always_comb begin
`ifdef KEY_AUTOREPEAT_EN
        tick_nxt = '0;
`endif
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i]   = state_q[i];
            pending_d[i] = pending_q[i];
`ifdef KEY_AUTOREPEAT_EN
            tcnt_d[i]    = tcnt_q[i];
`endif
            pulse_d[i]   = (pending_q[i] | rise[i]) & tick_game & ~mask[i];
            if (fall[i]) begin
                state_d[i]   = KS_IDLE;
                pending_d[i] = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                tcnt_d[i]    = '0;
`endif
            end else if (rise[i]) begin
                state_d[i]   = KS_DELAY;
                pending_d[i] = ~tick_game;
`ifdef KEY_AUTOREPEAT_EN
                tcnt_d[i]    = '0;
`endif
            end else if (tick_game) begin
                pending_d[i] = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                // The tick that consumes a pending pulse is not counted, giving N+1 ticks between pulses.
                if (REPEAT_MASK[i] && !pending_q[i]) begin
                    tick_nxt = tcnt_q[i] + 1'b1;
                    if (state_q[i] == KS_DELAY) begin
                        if (tick_nxt == DAS_LAST) begin
                            pending_d[i] = 1'b1;
                            state_d[i]   = KS_REPEAT;
                            tcnt_d[i]    = '0;
                        end else begin
                            tcnt_d[i] = tick_nxt;
                        end
                    end else if (state_q[i] == KS_REPEAT) begin
                        if (tick_nxt == ARR_LAST) begin
                            pending_d[i] = 1'b1;
                            tcnt_d[i]    = '0;
                        end else begin
                            tcnt_d[i] = tick_nxt;
                        end
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_q    <= '0;
            pending_q <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= KS_IDLE;
`ifdef KEY_AUTOREPEAT_EN
                tcnt_q[i]  <= '0;
`endif
            end
        end else begin
            held_q    <= acc_lvl;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
`ifdef KEY_AUTOREPEAT_EN
                tcnt_q[i]  <= tcnt_d[i];
`endif
            end
        end
    end

    assign key_pulse = pulse_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat settings and a tick every 10 cycles.
`timescale 1ns/1ps
module tb_key_conditioner;

    localparam int DEB = 4;
    localparam int DAS = 3;
    localparam int ARR = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_game;
    logic [4:0] key_raw;
    logic [4:0] key_pulse;
    logic [4:0] key_held;

    int checks   = 0;
    int failures = 0;
    int tphase   = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .DAS_TICKS      (DAS),
        .ARR_TICKS      (ARR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_game(tick_game),
        .key_raw  (key_raw),
        .key_pulse(key_pulse),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, let the edge pass, return at the falling edge with outputs settled.
    task automatic cyc(input logic [4:0] raw, input logic rstn);
        key_raw   = raw;
        rst_n     = rstn;
        tick_game = (tphase == 9);
        tphase    = (tphase + 1) % 10;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int phase);
        cyc(5'b00000, 1'b0);
        cyc(5'b00000, 1'b0);
        tphase = phase;
    endtask

    task automatic test_reset();
        cyc(5'b11111, 1'b0);
        cyc(5'b11111, 1'b0);
        cyc(5'b00000, 1'b0);
        checks++;
        if (key_held !== 5'b00000) begin
            failures++;
            $display("FAIL reset_held: got %b expected %b", key_held, 5'b00000);
        end
        checks++;
        if (key_pulse !== 5'b00000) begin
            failures++;
            $display("FAIL reset_pulse: got %b expected %b", key_pulse, 5'b00000);
        end
    endtask

    task automatic test_bounce();
        int held_hits = 0;
        int pulses    = 0;
        logic b;
        do_reset(0);
        for (int c = 0; c < 70; c++) begin
            b = (c < 40) && (((c / 3) % 2) == 0);
            cyc({4'b0000, b}, 1'b1);
            if (key_held[0] !== 1'b0) held_hits++;
            if (key_pulse !== 5'b00000) pulses++;
        end
        checks++;
        if (held_hits !== 0) begin
            failures++;
            $display("FAIL bounce_held: got %0d held cycles expected 0", held_hits);
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL bounce_pulse: got %0d pulse cycles expected 0", pulses);
        end
    endtask

    task automatic test_single_press();
        int held_cnt = 0;
        int rot_n    = 0;
        int rot_at   = -1;
        int other    = 0;
        do_reset(0);
        for (int c = 0; c < 130; c++) begin
            cyc((c < 100) ? 5'b01000 : 5'b00000, 1'b1);
            if (key_held[3] === 1'b1) held_cnt++;
            if (key_pulse[3] === 1'b1) begin
                rot_n++;
                rot_at = c;
            end
            if ((key_pulse & 5'b10111) !== 5'b00000) other++;
        end
        checks++;
        if (rot_n !== 1) begin
            failures++;
            $display("FAIL single_count: got %0d pulses expected 1", rot_n);
        end
        checks++;
        if (rot_at !== 9) begin
            failures++;
            $display("FAIL single_time: got cycle %0d expected 9", rot_at);
        end
        checks++;
        if (held_cnt !== 100) begin
            failures++;
            $display("FAIL single_held: got %0d cycles expected 100", held_cnt);
        end
        checks++;
        if (other !== 0) begin
            failures++;
            $display("FAIL single_other: got %0d stray pulses expected 0", other);
        end
    endtask

    task automatic test_autorepeat();
        int got[16];
        int got_n = 0;
        int exp_ar[8];
        int exp_n;
`ifdef KEY_AUTOREPEAT_EN
        exp_ar = '{9, 49, 79, 109, 139, 169, 199, 0};
        exp_n  = 7;
`else
        exp_ar = '{9, 0, 0, 0, 0, 0, 0, 0};
        exp_n  = 1;
`endif
        do_reset(0);
        for (int c = 0; c < 230; c++) begin
            cyc((c < 200) ? 5'b00001 : 5'b00000, 1'b1);
            if (key_pulse[0] === 1'b1) begin
                if (got_n < 16) got[got_n] = c;
                got_n++;
            end
        end
        checks++;
        if (got_n !== exp_n) begin
            failures++;
            $display("FAIL repeat_count: got %0d pulses expected %0d", got_n, exp_n);
        end
        for (int k = 0; k < exp_n; k++) begin
            checks++;
            if (k >= got_n || got[k] !== exp_ar[k]) begin
                failures++;
                $display("FAIL repeat_time[%0d]: got cycle %0d expected %0d", k,
                         (k < got_n) ? got[k] : -1, exp_ar[k]);
            end
        end
    endtask

    task automatic test_conflict();
        int got0[16];
        int got1[16];
        int n0 = 0;
        int n1 = 0;
        int viol = 0;
        logic both_prev = 1'b0;
        int exp0[2];
        int exp1[4];
        int e0;
        int e1;
        logic [4:0] raw;
`ifdef KEY_AUTOREPEAT_EN
        exp0 = '{9, 49};
        exp1 = '{159, 189, 219, 249};
        e0   = 2;
        e1   = 4;
`else
        exp0 = '{9, 0};
        exp1 = '{0, 0, 0, 0};
        e0   = 1;
        e1   = 0;
`endif
        do_reset(0);
        for (int c = 0; c < 270; c++) begin
            raw    = 5'b00000;
            raw[0] = (c < 150);
            raw[1] = (c >= 50) && (c < 250);
            cyc(raw, 1'b1);
            if (both_prev && (key_pulse[1:0] !== 2'b00)) viol++;
            both_prev = key_held[0] & key_held[1];
            if (key_pulse[0] === 1'b1) begin
                if (n0 < 16) got0[n0] = c;
                n0++;
            end
            if (key_pulse[1] === 1'b1) begin
                if (n1 < 16) got1[n1] = c;
                n1++;
            end
        end
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL conflict_masked: got %0d pulses while both held expected 0", viol);
        end
        checks++;
        if (n0 !== e0) begin
            failures++;
            $display("FAIL conflict_left_count: got %0d expected %0d", n0, e0);
        end
        checks++;
        if (n1 !== e1) begin
            failures++;
            $display("FAIL conflict_right_count: got %0d expected %0d", n1, e1);
        end
        for (int k = 0; k < e0; k++) begin
            checks++;
            if (k >= n0 || got0[k] !== exp0[k]) begin
                failures++;
                $display("FAIL conflict_left_time[%0d]: got cycle %0d expected %0d", k,
                         (k < n0) ? got0[k] : -1, exp0[k]);
            end
        end
        for (int k = 0; k < e1; k++) begin
            checks++;
            if (k >= n1 || got1[k] !== exp1[k]) begin
                failures++;
                $display("FAIL conflict_right_time[%0d]: got cycle %0d expected %0d", k,
                         (k < n1) ? got1[k] : -1, exp1[k]);
            end
        end
    endtask

    task automatic test_press_on_tick();
        int total = 0;
        do_reset(3);
        for (int c = 0; c < 60; c++) begin
            cyc((c < 40) ? 5'b01000 : 5'b00000, 1'b1);
            if (key_pulse !== 5'b00000) total++;
            if (c == 5) begin
                checks++;
                if (key_held !== 5'b00000) begin
                    failures++;
                    $display("FAIL ontick_pre_held: got %b expected %b", key_held, 5'b00000);
                end
            end
            if (c == 6) begin
                checks++;
                if (key_pulse !== 5'b01000) begin
                    failures++;
                    $display("FAIL ontick_pulse: got %b expected %b", key_pulse, 5'b01000);
                end
                checks++;
                if (key_held !== 5'b01000) begin
                    failures++;
                    $display("FAIL ontick_held: got %b expected %b", key_held, 5'b01000);
                end
            end
        end
        checks++;
        if (total !== 1) begin
            failures++;
            $display("FAIL ontick_total: got %0d pulse cycles expected 1", total);
        end
    endtask

    task automatic test_reset_midhold();
        int late = 0;
        do_reset(0);
        for (int c = 0; c < 51; c++) begin
            cyc(5'b10000, (c != 31));
            if (c > 31 && key_pulse !== 5'b00000) late++;
            if (c == 9) begin
                checks++;
                if (key_pulse !== 5'b10000) begin
                    failures++;
                    $display("FAIL rstmid_first_pulse: got %b expected %b", key_pulse, 5'b10000);
                end
            end
            if (c == 30) begin
                checks++;
                if (key_held !== 5'b10000) begin
                    failures++;
                    $display("FAIL rstmid_pre_held: got %b expected %b", key_held, 5'b10000);
                end
            end
            if (c == 31) begin
                checks++;
                if ({key_held, key_pulse} !== 10'b0) begin
                    failures++;
                    $display("FAIL rstmid_cleared: got held=%b pulse=%b expected 00000/00000", key_held, key_pulse);
                end
            end
            if (c == 37) begin
                checks++;
                if (key_held !== 5'b00000) begin
                    failures++;
                    $display("FAIL rstmid_early_held: got %b expected %b", key_held, 5'b00000);
                end
            end
            if (c == 38) begin
                checks++;
                if (key_held !== 5'b10000) begin
                    failures++;
                    $display("FAIL rstmid_reheld: got %b expected %b", key_held, 5'b10000);
                end
            end
            if (c == 39) begin
                checks++;
                if (key_pulse !== 5'b10000) begin
                    failures++;
                    $display("FAIL rstmid_new_pulse: got %b expected %b", key_pulse, 5'b10000);
                end
            end
        end
        checks++;
        if (late !== 1) begin
            failures++;
            $display("FAIL rstmid_pulse_count: got %0d expected 1", late);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        key_raw   = 5'b00000;
        rst_n     = 1'b0;
        tick_game = 1'b0;
        test_reset();
        test_bounce();
        test_single_press();
        test_autorepeat();
        test_conflict();
        test_press_on_tick();
        test_reset_midhold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
